// File: rtl/edge_detector.sv
// Frame-based 3x3 Sobel edge detector: loads one raster-order frame, computes
// zero-padded |Gx|+|Gy| saturated to 8 bits, then streams the result frame out.
module edge_detector #(
   parameter int unsigned KX_SIZE    = 3,
   parameter int unsigned KY_SIZE    = 3,
   parameter int unsigned IMG_X_SIZE = 3,
   parameter int unsigned IMG_Y_SIZE = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] GrayImage_i,
   input  logic       start_i,
   output logic       dataAvailable_o,
   output logic       valid_o,
   output logic [7:0] ProcessedImagePixel_o
);

   localparam int unsigned N  = IMG_X_SIZE * IMG_Y_SIZE;
   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned XW = (IMG_X_SIZE > 1) ? $clog2(IMG_X_SIZE) : 1;
   localparam int unsigned YW = (IMG_Y_SIZE > 1) ? $clog2(IMG_Y_SIZE) : 1;
   localparam int unsigned GW = 12;
   localparam int          KXH = int'(KX_SIZE / 2);
   localparam int          KYH = int'(KY_SIZE / 2);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_READY   = 3'd4;
   localparam logic [2:0] S_OUTPUT  = 3'd5;

   logic [2:0]    state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [XW-1:0] col, col_nx;
   logic [YW-1:0] row, row_nx;
   logic          last;

   logic [7:0] in_buf  [N];
   logic [7:0] out_buf [N];

   logic [7:0]          nb [KY_SIZE][KX_SIZE];
   logic signed [GW-1:0] sp [3][3];
   logic signed [GW-1:0] gx, gy, ax, ay;
   logic [GW-1:0]        mag;
   logic [7:0]           mag_sat;

   assign last = (cnt == CW'(N - 1));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state and counter sequencing
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      row_nx   = row;
      col_nx   = col;
      case (state)
         S_IDLE:  if (start_i) state_nx = S_ARMED;
         S_ARMED: begin
            if (!start_i) begin
               state_nx = S_LOAD;
               cnt_nx   = '0;
            end
         end
         S_LOAD: begin
            if (last) begin
               state_nx = S_COMPUTE;
               cnt_nx   = '0;
               row_nx   = '0;
               col_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_COMPUTE: begin
            if (last) begin
               state_nx = S_READY;
               cnt_nx   = '0;
               row_nx   = '0;
               col_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
               if (col == XW'(IMG_X_SIZE - 1)) begin
                  col_nx = '0;
                  row_nx = row + YW'(1);
               end else begin
                  col_nx = col + XW'(1);
               end
            end
         end
         S_READY: begin
            state_nx = S_OUTPUT;
            cnt_nx   = '0;
         end
         S_OUTPUT: begin
            if (last) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Neighbourhood fetch; out-of-image taps read as zero
   always_comb begin
      for (int i = 0; i < int'(KY_SIZE); i++) begin
         for (int j = 0; j < int'(KX_SIZE); j++) begin
            nb[i][j] = 8'd0;
            if ((int'(row) + i - KYH >= 0) && (int'(row) + i - KYH < int'(IMG_Y_SIZE)) &&
                (int'(col) + j - KXH >= 0) && (int'(col) + j - KXH < int'(IMG_X_SIZE)))
               nb[i][j] = in_buf[AW'((int'(row) + i - KYH) * int'(IMG_X_SIZE) +
                                     int'(col) + j - KXH)];
         end
      end
   end

   // Sobel magnitude with saturation
   always_comb begin
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            sp[i][j] = $signed(GW'(nb[i][j]));
      gx = (sp[0][2] + (sp[1][2] <<< 1) + sp[2][2]) - (sp[0][0] + (sp[1][0] <<< 1) + sp[2][0]);
      gy = (sp[2][0] + (sp[2][1] <<< 1) + sp[2][2]) - (sp[0][0] + (sp[0][1] <<< 1) + sp[0][2]);
      ax = gx[GW-1] ? -gx : gx;
      ay = gy[GW-1] ? -gy : gy;
      mag     = $unsigned(ax) + $unsigned(ay);
      mag_sat = (mag > GW'(255)) ? 8'hFF : mag[7:0];
   end

   // Frame buffers; contents are don't-care after reset
   always_ff @(posedge clk_i) begin
      if (state == S_LOAD)    in_buf[AW'(cnt)]  <= GrayImage_i;
      if (state == S_COMPUTE) out_buf[AW'(cnt)] <= mag_sat;
   end

   // Counters and registered outputs, aligned with the next state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt                   <= '0;
         row                   <= '0;
         col                   <= '0;
         dataAvailable_o       <= 1'b0;
         valid_o               <= 1'b0;
         ProcessedImagePixel_o <= 8'd0;
      end else begin
         cnt                   <= cnt_nx;
         row                   <= row_nx;
         col                   <= col_nx;
         dataAvailable_o       <= (state_nx == S_READY) || (state_nx == S_OUTPUT);
         valid_o               <= (state_nx == S_OUTPUT);
         ProcessedImagePixel_o <= (state_nx == S_OUTPUT) ? out_buf[AW'(cnt_nx)] : 8'd0;
      end
   end

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector: 3x3 and 4x2 instances, directed and
// randomized frames checked against a direct Sobel reference model.
module tb_edge_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pix;
   logic       start3, start42;
   logic       da3, v3, da42, v42;
   logic [7:0] px3, px42;

   int tests  = 0;
   int failed = 0;
   int got[$];

   always #5 clk = ~clk;

   edge_detector #(.KX_SIZE(3), .KY_SIZE(3), .IMG_X_SIZE(3), .IMG_Y_SIZE(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .GrayImage_i(pix), .start_i(start3),
      .dataAvailable_o(da3), .valid_o(v3), .ProcessedImagePixel_o(px3));

   edge_detector #(.KX_SIZE(3), .KY_SIZE(3), .IMG_X_SIZE(4), .IMG_Y_SIZE(2)) dut42 (
      .clk_i(clk), .rst_i(rst), .GrayImage_i(pix), .start_i(start42),
      .dataAvailable_o(da42), .valid_o(v42), .ProcessedImagePixel_o(px42));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int px_at(input int img[$], input int xs, input int ys,
                                input int r, input int c);
      if (r < 0 || r >= ys || c < 0 || c >= xs) return 0;
      return img[r * xs + c];
   endfunction

   // Sobel reference straight from the operator definition, integer arithmetic
   function automatic int model(input int img[$], input int xs, input int ys,
                                input int r, input int c);
      int gx, gy, m;
      gx = (px_at(img, xs, ys, r-1, c+1) + 2 * px_at(img, xs, ys, r, c+1) + px_at(img, xs, ys, r+1, c+1))
         - (px_at(img, xs, ys, r-1, c-1) + 2 * px_at(img, xs, ys, r, c-1) + px_at(img, xs, ys, r+1, c-1));
      gy = (px_at(img, xs, ys, r+1, c-1) + 2 * px_at(img, xs, ys, r+1, c) + px_at(img, xs, ys, r+1, c+1))
         - (px_at(img, xs, ys, r-1, c-1) + 2 * px_at(img, xs, ys, r-1, c) + px_at(img, xs, ys, r-1, c+1));
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (m > 255) ? 255 : m;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start3 = v;
      else          start42 = v;
   endtask

   task automatic read_out(input int sel, output int d, output int v, output int p);
      if (sel == 0) begin d = int'(da3);  v = int'(v3);  p = int'(px3);  end
      else          begin d = int'(da42); v = int'(v42); p = int'(px42); end
   endtask

   // Start, load, wait for READY, read out and check one whole frame
   task automatic run_frame(input int sel, input int xs, input int ys, input int img[$],
                            input int hold, input bit pulse_load, input bit pulse_out,
                            input string tag);
      int n, d, v, p, wc, seen;
      n = xs * ys;
      got.delete();
      set_start(sel, 1'b1);
      repeat (hold) tick();
      set_start(sel, 1'b0);
      tick();
      for (int i = 0; i < n; i++) begin
         pix = 8'(img[i]);
         set_start(sel, (pulse_load && i == 1) ? 1'b1 : 1'b0);
         tick();
      end
      set_start(sel, 1'b0);
      pix = 8'($urandom);
      wc = 0;
      read_out(sel, d, v, p);
      while (d == 0 && wc < 4 * n + 8) begin
         tick();
         wc++;
         read_out(sel, d, v, p);
      end
      chk({tag, "_ready_latency"}, wc, n);
      chk({tag, "_ready_valid"}, v, 0);
      chk({tag, "_ready_pixel"}, p, 0);
      for (int i = 0; i < n; i++) begin
         set_start(sel, (pulse_out && i == 1) ? 1'b1 : 1'b0);
         pix = 8'($urandom);
         tick();
         read_out(sel, d, v, p);
         chk($sformatf("%s_da[%0d]", tag, i), d, 1);
         chk($sformatf("%s_valid[%0d]", tag, i), v, 1);
         chk($sformatf("%s_pix[%0d]", tag, i), p, model(img, xs, ys, i / xs, i % xs));
         got.push_back(p);
      end
      set_start(sel, 1'b0);
      tick();
      read_out(sel, d, v, p);
      chk({tag, "_end_da"}, d, 0);
      chk({tag, "_end_valid"}, v, 0);
      chk({tag, "_end_pixel"}, p, 0);
      seen = 0;
      repeat (3 * n + 4) begin
         tick();
         read_out(sel, d, v, p);
         seen = seen | d | v;
      end
      chk({tag, "_no_second_frame"}, seen, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int img[$];
      int first[$];
      int seen;

      rst = 1'b1; pix = 8'd0; start3 = 1'b0; start42 = 1'b0;
      tick(); tick();
      chk("rst_da3", int'(da3), 0);
      chk("rst_v3", int'(v3), 0);
      chk("rst_px3", int'(px3), 0);
      chk("rst_da42", int'(da42), 0);
      chk("rst_v42", int'(v42), 0);
      chk("rst_px42", int'(px42), 0);
      rst = 1'b0;
      tick();

      img = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      run_frame(0, 3, 3, img, 2, 1'b0, 1'b0, "ramp");
      chk("ramp_corner", got[0], 22);
      chk("ramp_center", got[4], 32);
      first = got;

      img = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
      run_frame(0, 3, 3, img, 1, 1'b0, 1'b0, "flat10");
      chk("flat10_center", got[4], 0);
      chk("flat10_corner", got[0], 60);
      chk("flat10_edge", got[1], 40);

      img = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
      run_frame(0, 3, 3, img, 1, 1'b0, 1'b0, "white");
      chk("white_center", got[4], 0);
      for (int i = 0; i < 9; i++)
         if (i != 4) chk($sformatf("white_border[%0d]", i), got[i], 255);

      // Reset in the middle of COMPUTE
      img = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      start3 = 1'b1; tick(); start3 = 1'b0; tick();
      for (int i = 0; i < 9; i++) begin pix = 8'(img[i]); tick(); end
      tick(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_da", int'(da3), 0);
      chk("midrst_v", int'(v3), 0);
      chk("midrst_px", int'(px3), 0);
      seen = 0;
      repeat (30) begin tick(); seen = seen | int'(da3) | int'(v3); end
      chk("midrst_idle", seen, 0);
      run_frame(0, 3, 3, img, 3, 1'b0, 1'b0, "after_rst");
      for (int i = 0; i < 9; i++) chk($sformatf("after_rst_same[%0d]", i), got[i], first[i]);

      img.delete();
      for (int i = 0; i < 9; i++) img.push_back(int'($urandom_range(0, 255)));
      run_frame(0, 3, 3, img, 2, 1'b1, 1'b1, "stray_start");

      img = '{0, 0, 0, 0, 100, 100, 100, 100};
      run_frame(1, 4, 2, img, 2, 1'b0, 1'b0, "wide");
      chk("wide_inner1", got[1], 255);
      chk("wide_inner2", got[2], 255);

      for (int k = 0; k < 4; k++) begin
         img.delete();
         for (int i = 0; i < 9; i++) img.push_back(int'($urandom_range(0, 255)));
         run_frame(0, 3, 3, img, int'($urandom_range(1, 4)), 1'b0, 1'b0, $sformatf("rnd3_%0d", k));
         img.delete();
         for (int i = 0; i < 8; i++) img.push_back(int'($urandom_range(0, 255)));
         run_frame(1, 4, 2, img, int'($urandom_range(1, 4)), 1'b0, 1'b0, $sformatf("rnd42_%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
